// File: rtl/wreg_pkg.sv
// wreg_pkg: shared FSM state type and counter-width helper for the weight ping-pong bank
package wreg_pkg;
   typedef enum logic [1:0] {EMPTY, LOADING, FULL} wreg_state_t;
   function automatic int cw(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction
endpackage

// File: rtl/wreg_pingpong_if.sv
// wreg_pingpong_if: load/swap/readout bundle; master = upstream loader + PEs, slave = bank
//   i_valid/i_data/o_ready : serial weight load handshake
//   i_swap/o_swap_ack      : level swap request, one-cycle ack
//   o_full/o_act_valid     : shadow tile complete / active tile present
//   o_data                 : NCH active weights, channel k at [k*WIDTH +: WIDTH]
//   o_zero                 : per-channel zero flags (only with WREG_ZERO_FLAG_EN)
interface wreg_pingpong_if #(parameter int WIDTH = 16, parameter int NCH = 4);
   logic i_valid, o_ready, i_swap, o_swap_ack, o_full, o_act_valid;
   logic signed [WIDTH-1:0] i_data;
   logic [NCH*WIDTH-1:0] o_data;
`ifdef WREG_ZERO_FLAG_EN
   logic [NCH-1:0] o_zero;
   modport master (output i_valid, i_data, i_swap, input o_ready, o_swap_ack, o_full, o_act_valid, o_data, o_zero);
   modport slave (input i_valid, i_data, i_swap, output o_ready, o_swap_ack, o_full, o_act_valid, o_data, o_zero);
`else
   modport master (output i_valid, i_data, i_swap, input o_ready, o_swap_ack, o_full, o_act_valid, o_data);
   modport slave (input i_valid, i_data, i_swap, output o_ready, o_swap_ack, o_full, o_act_valid, o_data);
`endif
endinterface

// File: rtl/wreg_cell.sv
// wreg_cell: one shadow/active weight pair; optional zero flag under WREG_ZERO_FLAG_EN
//   clk, rst_n (async low), clr (sync), wr_en loads d into shadow,
//   swap copies shadow to q, zero = registered (active == 0)
module wreg_cell #(parameter int WIDTH = 16) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    wr_en,
   input  logic                    swap,
   input  logic signed [WIDTH-1:0] d,
`ifdef WREG_ZERO_FLAG_EN
   output logic                    zero,
`endif
   output logic signed [WIDTH-1:0] q
);
   logic signed [WIDTH-1:0] shadow;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shadow <= '0;
         q      <= '0;
      end else if (clr) begin
         shadow <= '0;
         q      <= '0;
      end else begin
         if (wr_en) shadow <= d;
         if (swap) q <= shadow;
      end
`ifdef WREG_ZERO_FLAG_EN
   // flag tracks the word being swapped in, so it lines up with q
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) zero <= 1'b1;
      else if (clr) zero <= 1'b1;
      else if (swap) zero <= (shadow == '0);
`endif
endmodule

// File: rtl/wreg_pingpong.sv
// wreg_pingpong: double-buffered weight bank for one systolic row; loads next tile while current computes
//   clk, rst_n (async low), clr (sync clear), bus (wreg_pingpong_if.slave)
//   optional per-channel zero flags with WREG_ZERO_FLAG_EN
module wreg_pingpong
   import wreg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NCH   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   wreg_pingpong_if.slave bus
);
   localparam int CW = cw(NCH);
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);
   wreg_state_t state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic ack_q, act_q, beat, fire, last;
   assign bus.o_ready     = (state_q != FULL);
   assign bus.o_full      = (state_q == FULL);
   assign bus.o_swap_ack  = ack_q;
   assign bus.o_act_valid = act_q;
   assign beat = bus.i_valid & bus.o_ready;
   // load and swap are exclusive: beats need !FULL, swaps need FULL
   assign fire = bus.i_swap & bus.o_full;
   assign last = (cnt_q == LAST);
   always_comb begin
      state_d = state_q;
      state_d = clr ? EMPTY : beat ? (last ? FULL : LOADING) : fire ? EMPTY : state_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= clr ? '0 : beat ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
         ack_q   <= ~clr & fire;
         act_q   <= ~clr & (act_q | fire);
      end
   for (genvar k = 0; k < NCH; k++) begin : g_cell
      wreg_cell #(.WIDTH(WIDTH)) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .wr_en (beat && cnt_q == CW'(k)),
         .swap  (fire),
         .d     (bus.i_data),
`ifdef WREG_ZERO_FLAG_EN
         .zero  (bus.o_zero[k]),
`endif
         .q     (bus.o_data[k*WIDTH +: WIDTH])
      );
   end
endmodule

// File: tb/tb_wreg_pingpong.sv
// tb_wreg_pingpong: directed self-checking bench for wreg_pingpong (WIDTH=16, NCH=4)
module tb_wreg_pingpong;
   logic clk, rst_n, clr;
   int n_vec = 0, n_err = 0;
   wreg_pingpong_if #(.WIDTH(16), .NCH(4)) bus ();
   wreg_pingpong #(.WIDTH(16), .NCH(4)) dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input logic [15:0] d);
      bus.i_valid = 1'b1;
      bus.i_data  = d;
      tick();
      bus.i_valid = 1'b0;
   endtask
   task automatic load4(input logic [15:0] a, b, c, d);
      beat(a);
      beat(b);
      beat(c);
      beat(d);
   endtask
   task automatic swap_chk(input string tag, input logic [63:0] exp);
      bus.i_swap = 1'b1;
      tick();
      bus.i_swap = 1'b0;
      check({tag, "_ack"}, 64'(bus.o_swap_ack), 64'd1);
      check({tag, "_data"}, bus.o_data, exp);
   endtask
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      rst_n = 1'b0; clr = 1'b0;
      bus.i_valid = 1'b0; bus.i_swap = 1'b0; bus.i_data = '0;
      #1;
      check("rst_ready", 64'(bus.o_ready), 64'd1);
      check("rst_full", 64'(bus.o_full), 64'd0);
      check("rst_act", 64'(bus.o_act_valid), 64'd0);
      check("rst_ack", 64'(bus.o_swap_ack), 64'd0);
      check("rst_data", bus.o_data, 64'd0);
`ifdef WREG_ZERO_FLAG_EN
      check("rst_zero", 64'(bus.o_zero), 64'hf);
`endif
      tick(); tick();
      rst_n = 1'b1;
      // 1: fill shadow, active untouched
      load4(16'h0001, 16'hffff, 16'h7fff, 16'h8000);
      check("t1_full", 64'(bus.o_full), 64'd1);
      check("t1_ready", 64'(bus.o_ready), 64'd0);
      check("t1_data", bus.o_data, 64'd0);
      check("t1_act", 64'(bus.o_act_valid), 64'd0);
      // 2: swap when full
      swap_chk("t2", 64'h8000_7fff_ffff_0001);
      check("t2_act", 64'(bus.o_act_valid), 64'd1);
      check("t2_full", 64'(bus.o_full), 64'd0);
      tick();
      check("t2_ack_low", 64'(bus.o_swap_ack), 64'd0);
      // 3: swap held from EMPTY, single ack on first FULL cycle
      bus.i_swap = 1'b1;
      for (int i = 0; i < 4; i++) begin
         beat(16'(i + 1));
         check("t3_noack", 64'(bus.o_swap_ack), 64'd0);
      end
      tick();
      check("t3_ack", 64'(bus.o_swap_ack), 64'd1);
      check("t3_data", bus.o_data, 64'h0004_0003_0002_0001);
      tick();
      check("t3_ack_once", 64'(bus.o_swap_ack), 64'd0);
      check("t3_empty", 64'(bus.o_ready), 64'd1);
      bus.i_swap = 1'b0;
      // 4: beats refused while full
      load4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
      bus.i_valid = 1'b1; bus.i_data = 16'hdead;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_ready", 64'(bus.o_ready), 64'd0);
         check("t4_full", 64'(bus.o_full), 64'd1);
      end
      bus.i_valid = 1'b0;
      swap_chk("t4", 64'h0040_0030_0020_0010);
      load4(16'h0055, 16'h0066, 16'h0077, 16'h0088);
      swap_chk("t4_ch0", 64'h0088_0077_0066_0055);
      // async reset mid-load discards partial tile
      beat(16'h0aaa);
      beat(16'h0bbb);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_data", bus.o_data, 64'd0);
      check("rst_mid_act", 64'(bus.o_act_valid), 64'd0);
      check("rst_mid_ready", 64'(bus.o_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      load4(16'h0009, 16'h000a, 16'h000b, 16'h000c);
      swap_chk("rst_mid", 64'h000c_000b_000a_0009);
      // 5: clr mid-load overrides a beat in the same cycle
      beat(16'h000a);
      beat(16'h000b);
      clr = 1'b1; bus.i_valid = 1'b1; bus.i_data = 16'h000c;
      tick();
      clr = 1'b0; bus.i_valid = 1'b0;
      check("t5_data", bus.o_data, 64'd0);
      check("t5_act", 64'(bus.o_act_valid), 64'd0);
      check("t5_ready", 64'(bus.o_ready), 64'd1);
      beat(16'h0001); beat(16'h0002); beat(16'h0003);
      check("t5_notfull", 64'(bus.o_full), 64'd0);
      beat(16'h0004);
      check("t5_full", 64'(bus.o_full), 64'd1);
      swap_chk("t5", 64'h0004_0003_0002_0001);
`ifdef WREG_ZERO_FLAG_EN
      // 6: zero flags follow the swapped tile, all ones after clr
      load4(16'h0000, 16'h0005, 16'h0000, 16'hfffd);
      swap_chk("t6", 64'hfffd_0000_0005_0000);
      check("t6_zero", 64'(bus.o_zero), 64'h5);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t6_zero_clr", 64'(bus.o_zero), 64'hf);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
